// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with valid/ready load and framing flags
// Words stream back to back: a new word is accepted on the edge that retires the last bit.
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter int   MSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt, cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             dout_next, valid_next, last_next;
  logic             at_last, accept;

  // shreg holds only the bits not yet driven; dout carries the current one
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  always_comb begin
    at_last    = (state == SHIFT) && (bit_cnt == LAST_CNT);
    din_ready  = (state == IDLE) || at_last;
    accept     = din_valid && din_ready;
    state_next = state;
    cnt_next   = bit_cnt;
    shreg_next = shreg;
    dout_next  = dout;
    valid_next = sout_valid;
    last_next  = sout_last;
    if (accept) begin
      state_next = SHIFT;
      cnt_next   = '0;
      shreg_next = drop_bit(din);
      dout_next  = first_bit(din);
      valid_next = 1'b1;
      last_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dout_next  = IDLE_LEVEL;
          valid_next = 1'b0;
          last_next  = 1'b0;
        end
        SHIFT: begin
          if (at_last) begin
            state_next = IDLE;
            cnt_next   = '0;
            dout_next  = IDLE_LEVEL;
            valid_next = 1'b0;
            last_next  = 1'b0;
          end else begin
            cnt_next   = bit_cnt + CNT_W'(1);
            shreg_next = drop_bit(shreg);
            dout_next  = first_bit(shreg);
            valid_next = 1'b1;
            last_next  = ((bit_cnt + CNT_W'(1)) == LAST_CNT);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      dout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= cnt_next;
      shreg      <= shreg_next;
      dout       <= dout_next;
      sout_valid <= valid_next;
      sout_last  <= last_next;
    end
  end

  assign busy = sout_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed and random checks of piso_serializer in both bit orders
module tb_piso_serializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         din_valid;
  logic [W-1:0] din;
  logic ready_l, dout_l, sv_l, sl_l, busy_l;
  logic ready_m, dout_m, sv_m, sl_m, busy_m;

  typedef struct {
    logic [W-1:0] word;
    int           idx;
  } item_t;

  item_t q[$];
  int compared = 0;
  int mismatched = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(ready_l), .dout(dout_l), .sout_valid(sv_l), .sout_last(sl_l), .busy(busy_l)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(ready_m), .dout(dout_m), .sout_valid(sv_m), .sout_last(sl_m), .busy(busy_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model: queue of bits still to appear on the line; head is what dout shows now.
  task automatic tick();
    bit           acc;
    logic [W-1:0] word;
    item_t        it;
    logic         rdy;
    rdy  = (q.size() <= 1);
    word = din;
    if (!reset) begin
      chk("din_ready_lsb", ready_l, rdy);
      chk("din_ready_msb", ready_m, rdy);
    end
    acc = !reset && din_valid && rdy;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          it.word = word;
          it.idx  = i;
          q.push_back(it);
        end
      end
    end
    if (q.size() == 0) begin
      chk("dout_idle_lsb", dout_l, 1'b1);
      chk("dout_idle_msb", dout_m, 1'b1);
      chk("valid_idle_lsb", sv_l, 1'b0);
      chk("valid_idle_msb", sv_m, 1'b0);
      chk("last_idle_lsb", sl_l, 1'b0);
      chk("last_idle_msb", sl_m, 1'b0);
      chk("busy_idle_lsb", busy_l, 1'b0);
      chk("busy_idle_msb", busy_m, 1'b0);
    end else begin
      it = q[0];
      chk("dout_lsb", dout_l, it.word[it.idx]);
      chk("dout_msb", dout_m, it.word[W-1-it.idx]);
      chk("valid_lsb", sv_l, 1'b1);
      chk("valid_msb", sv_m, 1'b1);
      chk("last_lsb", sl_l, it.idx == W-1);
      chk("last_msb", sl_m, it.idx == W-1);
      chk("busy_lsb", busy_l, 1'b1);
      chk("busy_msb", busy_m, 1'b1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    din_valid = 1'b1;
    din       = 4'hC;
    tick();
    tick();
    reset     = 1'b0;
    din_valid = 1'b0;
    tick();

    // single word 1011
    din       = 4'b1011;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = W'($urandom);
    repeat (5) tick();

    // single word 1000
    din       = 4'b1000;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (5) tick();

    // back-to-back A then 5 with valid held high
    din       = 4'hA;
    din_valid = 1'b1;
    tick();
    repeat (3) begin
      din = W'($urandom);
      tick();
    end
    din = 4'h5;
    tick();
    din_valid = 1'b0;
    repeat (5) tick();

    // held-off request for F while 0 is shifting
    din       = 4'h0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    din       = 4'hF;
    din_valid = 1'b1;
    repeat (3) tick();
    din_valid = 1'b0;
    repeat (6) tick();

    // reset at bit_cnt 2 of 0110
    din       = 4'b0110;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();

    repeat (400) begin
      reset     = ($urandom_range(0, 49) == 0);
      din_valid = ($urandom_range(0, 2) != 0);
      din       = W'($urandom);
      tick();
    end
    reset     = 1'b0;
    din_valid = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
